// File: rtl/chunked_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
package chunked_adder_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic int unsigned nch(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // A single-slice configuration still needs a 1-bit counter.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder slice, shared across cycles by the sequencer.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit adder processing CHUNK bits per clock through a registered carry.
// Define CHUNKED_ADDER_SUB_EN to add the `sub` port (a - b - carry_in).
module chunked_seq_adder
    import chunked_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef CHUNKED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned NCH = nch(WIDTH, CHUNK);
    localparam int unsigned IW  = idx_width(NCH);
    localparam logic [IW-1:0] LastIdx = IW'(NCH - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("chunked_seq_adder: WIDTH must be a multiple of CHUNK");
    end

    state_e            state;
    logic [IW-1:0]     idx;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_out_q;
    logic              overflow_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [CHUNK-1:0]  slice_s;
    logic              slice_cout;
    logic              slice_c_msb;
    logic              b_inv;

`ifdef CHUNKED_ADDER_SUB_EN
    assign b_inv = sub;
`else
    assign b_inv = 1'b0;
`endif

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a     (a_q[idx*CHUNK +: CHUNK]),
        .b     (b_q[idx*CHUNK +: CHUNK]),
        .cin   (carry_q),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            idx         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        // Subtraction folds into addition: invert b, invert the initial carry.
                        a_q        <= a;
                        b_q        <= b_inv ? ~b : b;
                        carry_q    <= carry_in ^ b_inv;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= StRun;
                    end
                end
                StRun: begin
                    sum_q[idx*CHUNK +: CHUNK] <= slice_s;
                    carry_q <= slice_cout;
                    idx     <= idx + 1'b1;
                    if (idx == LastIdx) begin
                        carry_out_q <= slice_cout;
                        overflow_q  <= slice_c_msb ^ slice_cout;
                        out_valid_q <= 1'b1;
                        state       <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed bench for chunked_seq_adder: default 16/4 instance plus 32/8 and 16/16 sweeps.
module tb_chunked_seq_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Main 16/4 instance
    logic        m_iv = 1'b0, m_ir, m_ov, m_or = 1'b0, m_ci = 1'b0, m_co, m_ovf;
    logic [15:0] m_a = '0, m_b = '0, m_sum;
`ifdef CHUNKED_ADDER_SUB_EN
    logic        m_sub = 1'b0;
`endif

    // 32/8 instance
    logic        w_iv = 1'b0, w_ir, w_ov, w_or = 1'b0, w_ci = 1'b0, w_co, w_ovf;
    logic [31:0] w_a = '0, w_b = '0, w_sum;

    // 16/16 instance (single slice)
    logic        n_iv = 1'b0, n_ir, n_ov, n_or = 1'b0, n_ci = 1'b0, n_co, n_ovf;
    logic [15:0] n_a = '0, n_b = '0, n_sum;

    chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) u_main (
        .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(m_ir), .a(m_a), .b(m_b),
        .carry_in(m_ci),
`ifdef CHUNKED_ADDER_SUB_EN
        .sub(m_sub),
`endif
        .out_valid(m_ov), .out_ready(m_or), .sum(m_sum), .carry_out(m_co), .overflow(m_ovf)
    );

    chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) u_wide (
        .clk(clk), .rst(rst), .in_valid(w_iv), .in_ready(w_ir), .a(w_a), .b(w_b),
        .carry_in(w_ci),
`ifdef CHUNKED_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(w_ov), .out_ready(w_or), .sum(w_sum), .carry_out(w_co), .overflow(w_ovf)
    );

    chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) u_one (
        .clk(clk), .rst(rst), .in_valid(n_iv), .in_ready(n_ir), .a(n_a), .b(n_b),
        .carry_in(n_ci),
`ifdef CHUNKED_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(n_ov), .out_ready(n_or), .sum(n_sum), .carry_out(n_co), .overflow(n_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set to the main instance and wait (bounded) for out_valid.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        output int lat);
        m_a  = a;
        m_b  = b;
        m_ci = ci;
        m_iv = 1'b1;
        step();
        m_iv = 1'b0;
        lat  = 0;
        while (!m_ov && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic take16();
        m_or = 1'b1;
        step();
        m_or = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [15:0] held_sum;
        logic        stable;

        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 64'(m_ir), 64'd1);
        check("rst_out_valid", 64'(m_ov), 64'd0);
        check("rst_sum_co_ovf", 64'({m_sum, m_co, m_ovf}), 64'd0);

        op16(16'd0, 16'd0, 1'b0, lat);
        check("v0_res", 64'({lat[7:0], m_co, m_sum}), 64'({8'd4, 1'b0, 16'd0}));
        check("v0_in_ready_busy", 64'(m_ir), 64'd0);
        take16();
        check("v0_in_ready_after", 64'({m_ir, m_ov}), 64'b10);

        op16(16'd1, 16'd1, 1'b1, lat);
        check("v1_res", 64'({lat[7:0], m_co, m_sum}), 64'({8'd4, 1'b0, 16'd3}));
        take16();
        op16(16'd65535, 16'd1, 1'b0, lat);
        check("v2_res", 64'({lat[7:0], m_co, m_sum}), 64'({8'd4, 1'b1, 16'd0}));
        take16();
        op16(16'd49151, 16'd65535, 1'b0, lat);
        check("v3_res", 64'({lat[7:0], m_co, m_ovf, m_sum}), 64'({8'd4, 2'b10, 16'd49150}));
        take16();
        op16(16'd65535, 16'd65535, 1'b0, lat);
        check("v4_res", 64'({lat[7:0], m_co, m_ovf, m_sum}), 64'({8'd4, 2'b10, 16'd65534}));
        take16();

        op16(16'h7FFF, 16'h0001, 1'b0, lat);
        check("ovf_pos", 64'({m_co, m_ovf, m_sum}), 64'({2'b01, 16'h8000}));
        take16();
        op16(16'h8000, 16'h8000, 1'b0, lat);
        check("ovf_neg", 64'({m_co, m_ovf, m_sum}), 64'({2'b11, 16'h0000}));
        take16();

        // Backpressure: hold result while new operands are offered.
        op16(16'h1234, 16'h1111, 1'b0, lat);
        check("bp_first", 64'({m_co, m_sum}), 64'({1'b0, 16'h2345}));
        held_sum = m_sum;
        stable   = 1'b1;
        m_a  = 16'hAAAA;
        m_b  = 16'h5555;
        m_iv = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_sum !== held_sum || m_ov !== 1'b1 || m_ir !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_sum", 64'(m_sum), 64'h2345);
        m_iv = 1'b0;
        take16();
        check("bp_release", 64'({m_ir, m_ov}), 64'b10);
        m_or = 1'b1;
        step();
        step();
        m_or = 1'b0;
        check("bp_one_transfer", 64'({m_ir, m_ov}), 64'b10);

        // Reset in the second RUN cycle discards the operation.
        m_a  = 16'h0F0F;
        m_b  = 16'h0101;
        m_ci = 1'b0;
        m_iv = 1'b1;
        step();
        m_iv = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_state", 64'({m_ir, m_ov}), 64'b10);
        check("midrst_sum", 64'(m_sum), 64'd0);
        op16(16'd3, 16'd4, 1'b0, lat);
        check("midrst_fresh", 64'({lat[7:0], m_co, m_sum}), 64'({8'd4, 1'b0, 16'd7}));
        take16();

`ifdef CHUNKED_ADDER_SUB_EN
        m_sub = 1'b1;
        op16(16'd5, 16'd7, 1'b0, lat);
        check("sub_5_7", 64'({m_co, m_sum}), 64'({1'b0, 16'hFFFE}));
        take16();
        op16(16'd7, 16'd5, 1'b0, lat);
        check("sub_7_5", 64'({m_co, m_sum}), 64'({1'b1, 16'h0002}));
        take16();
        m_sub = 1'b0;
`endif

        // 32/8 sweep: latency 4, starting with the all-ones boundary.
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            logic        rc;
            logic [32:0] e;
            int          l;
            ra = (i == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            rb = (i == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            rc = (i == 0) ? 1'b1 : 1'($urandom_range(1));
            e  = {1'b0, ra} + {1'b0, rb} + 33'(rc);
            w_a  = ra;
            w_b  = rb;
            w_ci = rc;
            w_iv = 1'b1;
            step();
            w_iv = 1'b0;
            l = 0;
            while (!w_ov && l < 20) begin
                step();
                l++;
            end
            check("sweep32", 64'({l[7:0], w_co, w_sum}), 64'({8'd4, e}));
            w_or = 1'b1;
            step();
            w_or = 1'b0;
        end

        // 16/16 sweep: single RUN cycle.
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            logic        rc;
            logic [16:0] e;
            int          l;
            ra = (i == 0) ? 16'hFFFF : 16'($urandom);
            rb = (i == 0) ? 16'h0000 : 16'($urandom);
            rc = (i == 0) ? 1'b1 : 1'($urandom_range(1));
            e  = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            n_a  = ra;
            n_b  = rb;
            n_ci = rc;
            n_iv = 1'b1;
            step();
            n_iv = 1'b0;
            l = 0;
            while (!n_ov && l < 20) begin
                step();
                l++;
            end
            check("sweep16x16", 64'({l[7:0], n_co, n_sum}), 64'({8'd1, e}));
            n_or = 1'b1;
            step();
            n_or = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
